// File: rtl/serial_bus_pkg.sv
// serial_bus_pkg
// Definitions shared by the master and slave sides of the serial bus:
// the default field widths, the instruction codes and the state type of
// the slave receive stage.
package serial_bus_pkg;

  localparam int DEF_SLAVE_ADDR_SIZE = 12;
  localparam int DEF_WORD_SIZE       = 8;
  localparam int DEF_BURST_SIZE      = 15;

  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_B_READ  = 3'd3;
  localparam logic [2:0] S_B_WRITE = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_RX,
    CMD,
    BURST_RX,
    DATA_RX,
    RD_ISSUE
  } state_t;

endpackage

// File: rtl/sipo_shift.sv
// sipo_shift
// LSB-first serial-in/parallel-out shifter with its own bit counter.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clr       restart the word; if en is also high, that bit becomes bit 0
//   en        shift bit_in in this cycle
//   bit_in    serial input bit
//   word      bits received so far (complete once WIDTH bits have arrived)
//   full      this cycle's enabled bit is the last bit of the word
// WIDTH must be at least 2.
module sipo_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word,
  output logic             full
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] count;

  // New bits enter at the top so that after WIDTH shifts the first bit
  // received has moved down to bit 0.
  assign full = en && !clr && (count == CW'(WIDTH - 1));

  // Clearing while enabled restarts the word with the current bit, so a
  // new transaction can begin in the very cycle the previous one ends.
  // The counter wraps on completion, which lets back-to-back words follow
  // without a gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      word  <= '0;
    end else if (clr) begin
      count <= en ? CW'(1) : '0;
      word  <= en ? {bit_in, {(WIDTH-1){1'b0}}} : '0;
    end else if (en) begin
      count <= full ? '0 : count + CW'(1);
      word  <= {bit_in, word[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/slave_in_port.sv
// slave_in_port
// Slave-side receive stage of the serial bus. Deserializes the address,
// burst length and write data, then issues write strobes to the slave core
// or hands a read request to the slave output port.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   sel                           this slave is selected by the master
//   addr_bus, burst_size_bus,
//   w_data_bus                    serial address / burst length / data bits
//   m_valid, m_b_tx_valid         data bit valid, burst-length bits valid
//   read_en, tx_done, split_on    read request, write done, abandon
//   rd_busy                       output port still serving a read
//   s_ready                       slave can accept serial traffic
//   mem_addr, mem_wdata, mem_we   write port to the slave core
//   rd_req, rd_addr, rd_len       read request to the slave output port
module slave_in_port
  import serial_bus_pkg::*;
#(
  parameter int SLAVE_ADDR_SIZE = DEF_SLAVE_ADDR_SIZE,
  parameter int WORD_SIZE       = DEF_WORD_SIZE,
  parameter int BURST_SIZE      = DEF_BURST_SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sel,
  input  logic                       addr_bus,
  input  logic                       burst_size_bus,
  input  logic                       w_data_bus,
  input  logic                       m_valid,
  input  logic                       m_b_tx_valid,
  input  logic                       read_en,
  input  logic                       tx_done,
  input  logic                       split_on,
  input  logic                       rd_busy,
  output logic                       s_ready,
  output logic [SLAVE_ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]       mem_wdata,
  output logic                       mem_we,
  output logic                       rd_req,
  output logic [SLAVE_ADDR_SIZE-1:0] rd_addr,
  output logic [BURST_SIZE-1:0]      rd_len
);

  state_t state_q, state_d;

  logic [SLAVE_ADDR_SIZE-1:0] addr_word, word_idx;
  logic [BURST_SIZE-1:0]      burst_word, burst_next, rd_len_d;
  logic [WORD_SIZE-1:0]       data_word, data_next;
  logic addr_en, addr_clr, addr_full;
  logic burst_en, burst_clr, burst_full;
  logic data_en, data_clr, data_full;
  logic abort, commit, load_rd, issue_rd;

  // Deselect or split abandons whatever is in flight.
  assign abort = (state_q != IDLE) && (split_on || !sel);

  // Shifter controls depend only on the current state and the inputs. The
  // bit seen in the cycle that enters a field is that field's bit 0.
  assign addr_clr  = (state_q == IDLE);
  assign addr_en   = ((state_q == IDLE) && sel) || ((state_q == ADDR_RX) && !abort);
  assign burst_clr = (state_q != BURST_RX);
  assign burst_en  = !abort && (((state_q == CMD) && m_b_tx_valid) || (state_q == BURST_RX));
  assign data_clr  = (state_q != DATA_RX);
  assign data_en   = m_valid && !abort &&
                     (((state_q == CMD) && !m_b_tx_valid && !read_en) || (state_q == DATA_RX));

  // The word as it will look once the current bit has been shifted in.
  assign burst_next = {burst_size_bus, burst_word[BURST_SIZE-1:1]};
  assign data_next  = {w_data_bus, data_word[WORD_SIZE-1:1]};

  sipo_shift #(.WIDTH(SLAVE_ADDR_SIZE)) u_addr_sipo (
    .clk(clk), .rst(rst), .clr(addr_clr), .en(addr_en), .bit_in(addr_bus),
    .word(addr_word), .full(addr_full)
  );

  sipo_shift #(.WIDTH(BURST_SIZE)) u_burst_sipo (
    .clk(clk), .rst(rst), .clr(burst_clr), .en(burst_en), .bit_in(burst_size_bus),
    .word(burst_word), .full(burst_full)
  );

  sipo_shift #(.WIDTH(WORD_SIZE)) u_data_sipo (
    .clk(clk), .rst(rst), .clr(data_clr), .en(data_en), .bit_in(w_data_bus),
    .word(data_word), .full(data_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state plus the one-cycle decisions that the output registers act on.
  always_comb begin
    state_d  = state_q;
    commit   = 1'b0;
    load_rd  = 1'b0;
    issue_rd = 1'b0;
    rd_len_d = rd_len;
    case (state_q)
      IDLE: begin
        if (sel) state_d = ADDR_RX;
      end
      ADDR_RX: begin
        if (abort)          state_d = IDLE;
        else if (addr_full) state_d = CMD;
      end
      CMD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (m_b_tx_valid) begin
          state_d = BURST_RX;
        end else if (read_en) begin
          state_d  = RD_ISSUE;
          load_rd  = 1'b1;
          rd_len_d = BURST_SIZE'(1);
        end else if (m_valid) begin
          state_d = DATA_RX;
        end
      end
      BURST_RX: begin
        if (abort) begin
          state_d = IDLE;
        end else if (burst_full) begin
          state_d  = RD_ISSUE;
          load_rd  = 1'b1;
          rd_len_d = (burst_next == '0) ? BURST_SIZE'(1) : burst_next;
        end
      end
      DATA_RX: begin
        // A word finishing together with tx_done is still written.
        if (abort) begin
          state_d = IDLE;
        end else begin
          commit = data_full;
          if (tx_done) state_d = IDLE;
        end
      end
      RD_ISSUE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!rd_busy) begin
          issue_rd = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs. word_idx counts words committed in the current
  // write so the target address walks up from the base and wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready   <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      rd_len    <= '0;
      word_idx  <= '0;
    end else begin
      mem_we  <= commit;
      rd_req  <= issue_rd;
      s_ready <= !((state_d == RD_ISSUE) || rd_busy);
      if (state_q == IDLE) begin
        word_idx <= '0;
      end else if (commit) begin
        word_idx <= word_idx + SLAVE_ADDR_SIZE'(1);
      end
      if (commit) begin
        mem_wdata <= data_next;
        mem_addr  <= addr_word + word_idx;
      end
      if (load_rd) begin
        rd_addr <= addr_word;
        rd_len  <= rd_len_d;
      end
    end
  end

endmodule

// File: tb/tb_slave_in_port.sv
// tb_slave_in_port
// Directed bench for slave_in_port: serial writes, burst writes with address
// wrap, burst and single reads, read back-pressure, aborts and reset.
module tb_slave_in_port;
  import serial_bus_pkg::*;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int BW = 15;

  logic clk = 1'b0;
  logic rst, sel, addr_bus, burst_size_bus, w_data_bus;
  logic m_valid, m_b_tx_valid, read_en, tx_done, split_on, rd_busy;
  logic s_ready, mem_we, rd_req;
  logic [AW-1:0] mem_addr, rd_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] rd_len;

  int errors = 0;
  int checks = 0;
  int weCount = 0;
  int rdCount = 0;

  slave_in_port #(.SLAVE_ADDR_SIZE(AW), .WORD_SIZE(DW), .BURST_SIZE(BW)) dut (
    .clk(clk), .rst(rst), .sel(sel), .addr_bus(addr_bus),
    .burst_size_bus(burst_size_bus), .w_data_bus(w_data_bus),
    .m_valid(m_valid), .m_b_tx_valid(m_b_tx_valid), .read_en(read_en),
    .tx_done(tx_done), .split_on(split_on), .rd_busy(rd_busy),
    .s_ready(s_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle catch stray or stretched strobes.
  always @(negedge clk) begin
    if (mem_we === 1'b1) weCount++;
    if (rd_req === 1'b1) rdCount++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input state_t expected);
    checkOutput(tag, 32'(dut.state_q), 32'(expected));
  endtask

  // Drive one cycle of inputs, then let it be clocked and settle.
  task automatic applyStimulus(input logic s, input logic a, input logic b,
                               input logic w, input logic mv, input logic btv,
                               input logic re, input logic td, input logic sp);
    sel = s; addr_bus = a; burst_size_bus = b; w_data_bus = w;
    m_valid = mv; m_b_tx_valid = btv; read_en = re; tx_done = td; split_on = sp;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic holdCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendAddr(input logic [AW-1:0] a);
    for (int i = 0; i < AW; i++)
      applyStimulus(1'b1, a[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendWord(input logic [DW-1:0] d, input logic last);
    for (int i = 0; i < DW; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, d[i], 1'b1, 1'b0, 1'b0,
                    last && (i == DW - 1), 1'b0);
  endtask

  task automatic sendBurst(input logic [BW-1:0] n);
    for (int i = 0; i < BW; i++)
      applyStimulus(1'b1, 1'b0, n[i], 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; addr_bus = 1'b0; burst_size_bus = 1'b0;
    w_data_bus = 1'b0; m_valid = 1'b0; m_b_tx_valid = 1'b0; read_en = 1'b0;
    tx_done = 1'b0; split_on = 1'b0; rd_busy = 1'b0;
    #12;
    checkOutput("reset s_ready", 32'(s_ready), 32'h1);
    checkOutput("reset mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("reset mem_wdata", 32'(mem_wdata), 32'h0);
    checkOutput("reset mem_we", 32'(mem_we), 32'h0);
    checkOutput("reset rd_req", 32'(rd_req), 32'h0);
    checkOutput("reset rd_addr", 32'(rd_addr), 32'h0);
    checkOutput("reset rd_len", 32'(rd_len), 32'h0);
    checkState("reset state", IDLE);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] single write");
    sendAddr(12'h0A5);
    checkState("addr latency", CMD);
    sendWord(8'h3C, 1'b0);
    checkOutput("wr1 mem_we", 32'(mem_we), 32'h1);
    checkOutput("wr1 mem_addr", 32'(mem_addr), 32'h0A5);
    checkOutput("wr1 mem_wdata", 32'(mem_wdata), 32'h3C);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkState("wr1 tx_done", IDLE);
    checkOutput("wr1 we one cycle", 32'(mem_we), 32'h0);
    checkOutput("wr1 we count", 32'(weCount), 32'd1);

    $display("[TB] burst write with wrap");
    sendAddr(12'hFFF);
    sendWord(8'h11, 1'b0);
    checkOutput("bw0 mem_addr", 32'(mem_addr), 32'hFFF);
    checkOutput("bw0 mem_wdata", 32'(mem_wdata), 32'h11);
    sendWord(8'h22, 1'b0);
    checkOutput("bw1 mem_addr", 32'(mem_addr), 32'h000);
    checkOutput("bw1 mem_wdata", 32'(mem_wdata), 32'h22);
    sendWord(8'h33, 1'b1);
    checkOutput("bw2 mem_we", 32'(mem_we), 32'h1);
    checkOutput("bw2 mem_addr", 32'(mem_addr), 32'h001);
    checkOutput("bw2 mem_wdata", 32'(mem_wdata), 32'h33);
    checkState("bw2 done with last word", IDLE);
    idleCycle();
    checkOutput("bw we count", 32'(weCount), 32'd4);

    $display("[TB] burst read");
    sendAddr(12'h010);
    sendBurst(15'd5);
    checkState("br enters RD_ISSUE", RD_ISSUE);
    checkOutput("br s_ready low", 32'(s_ready), 32'h0);
    checkOutput("br rd_req not yet", 32'(rd_req), 32'h0);
    holdCycle();
    checkOutput("br rd_req", 32'(rd_req), 32'h1);
    checkOutput("br rd_addr", 32'(rd_addr), 32'h010);
    checkOutput("br rd_len", 32'(rd_len), 32'd5);
    idleCycle();
    checkOutput("br rd_req one cycle", 32'(rd_req), 32'h0);
    checkOutput("br rd count", 32'(rdCount), 32'd1);

    sendAddr(12'h7FE);
    sendBurst(15'd0);
    holdCycle();
    checkOutput("br0 rd_req", 32'(rd_req), 32'h1);
    checkOutput("br0 rd_addr", 32'(rd_addr), 32'h7FE);
    checkOutput("br0 rd_len coerced", 32'(rd_len), 32'd1);
    idleCycle();
    checkOutput("br0 rd count", 32'(rdCount), 32'd2);

    $display("[TB] read with rd_busy");
    sendAddr(12'h123);
    rd_busy = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkState("rb enters RD_ISSUE", RD_ISSUE);
    checkOutput("rb s_ready low", 32'(s_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      holdCycle();
      checkOutput("rb rd_req held off", 32'(rd_req), 32'h0);
      checkOutput("rb s_ready busy", 32'(s_ready), 32'h0);
    end
    rd_busy = 1'b0;
    holdCycle();
    checkOutput("rb rd_req", 32'(rd_req), 32'h1);
    checkOutput("rb rd_addr", 32'(rd_addr), 32'h123);
    checkOutput("rb rd_len single", 32'(rd_len), 32'd1);
    checkOutput("rb s_ready back", 32'(s_ready), 32'h1);
    idleCycle();
    checkOutput("rb rd count", 32'(rdCount), 32'd3);

    $display("[TB] aborts");
    sendAddr(12'h055);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkState("split partial word", IDLE);
    idleCycle();
    checkOutput("split no mem_we", 32'(mem_we), 32'h0);

    sendAddr(12'h200);
    for (int i = 0; i < DW - 1; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkState("split on last bit", IDLE);
    checkOutput("split last bit no mem_we", 32'(mem_we), 32'h0);
    idleCycle();

    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle();
    checkState("sel drop mid-address", IDLE);
    idleCycle();
    checkOutput("abort we count", 32'(weCount), 32'd4);
    checkOutput("abort rd count", 32'(rdCount), 32'd3);

    $display("[TB] reset mid-transaction");
    sendAddr(12'h3C0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkState("rst state", IDLE);
    checkOutput("rst mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("rst mem_wdata", 32'(mem_wdata), 32'h0);
    checkOutput("rst rd_addr", 32'(rd_addr), 32'h0);
    checkOutput("rst rd_len", 32'(rd_len), 32'h0);
    checkOutput("rst s_ready", 32'(s_ready), 32'h1);
    idleCycle();
    rst = 1'b0;
    idleCycle();
    sendAddr(12'h3C0);
    sendWord(8'h2A, 1'b1);
    checkOutput("post-rst mem_we", 32'(mem_we), 32'h1);
    checkOutput("post-rst mem_addr", 32'(mem_addr), 32'h3C0);
    checkOutput("post-rst mem_wdata", 32'(mem_wdata), 32'h2A);
    idleCycle();
    checkOutput("post-rst we count", 32'(weCount), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slave_in_port.md
# slave_in_port

Slave-side receive stage of the serial bus, directly downstream of the master output port. It deserializes the LSB-first address, burst-length and write-data bit streams driven onto the shared serial lines into parallel words. It then either issues memory write strobes to the slave core or hands a read request to the slave output port. It drives `s_ready` back to the master and aborts cleanly on deselect or split.

## Interface
Parameters:
- `SLAVE_ADDR_SIZE`, 12, address width in bits (serial address length).
- `WORD_SIZE`, 8, data word width (serial bits per word).
- `BURST_SIZE`, 15, width of the serial burst-length field.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `sel`  in  1  this slave's bit of the master's `slave_select`.
- `addr_bus`  in  1  serial address bit.
- `burst_size_bus`  in  1  serial burst-length bit.
- `w_data_bus`  in  1  serial write-data bit.
- `m_valid`  in  1  write-data bit on `w_data_bus` is valid this cycle.
- `m_b_tx_valid`  in  1  burst-length bits are valid.
- `read_en`  in  1  master requests a read.
- `tx_done`  in  1  master finished the write transaction.
- `split_on`  in  1  master abandoned the transaction.
- `rd_busy`  in  1  slave output port still serving a read.
- `s_ready`  out  1  slave can accept serial traffic.
- `mem_addr`  out  SLAVE_ADDR_SIZE  write address to the slave core.
- `mem_wdata`  out  WORD_SIZE  write data to the slave core.
- `mem_we`  out  1  one-cycle write strobe.
- `rd_req`  out  1  one-cycle read request to the slave output port.
- `rd_addr`  out  SLAVE_ADDR_SIZE  read base address.
- `rd_len`  out  BURST_SIZE  number of words to read, minimum 1.

## Operation
States: IDLE, ADDR_RX, CMD, BURST_RX, DATA_RX, RD_ISSUE.
- IDLE:
  - Clears the bit and word counters.
  - On `sel`=1 → ADDR_RX. The bit on `addr_bus` in that same cycle is address bit 0.
- ADDR_RX:
  - Shifts one `addr_bus` bit per cycle into the address register, LSB first.
  - After bit SLAVE_ADDR_SIZE-1 is captured → CMD.
- CMD:
  - Priority order: `m_b_tx_valid` → BURST_RX; else `read_en` → RD_ISSUE with length 1; else `m_valid` → DATA_RX.
  - DATA_RX captures the bit present in this cycle as data bit 0.
  - With none of these asserted, the block waits in CMD.
- BURST_RX:
  - Shifts `burst_size_bus` bits LSB first, one per cycle, BURST_SIZE bits.
  - Then → RD_ISSUE. A received length of 0 is coerced to 1.
- RD_ISSUE:
  - Waits while `rd_busy`=1.
  - When `rd_busy`=0, pulses `rd_req` for 1 cycle with `rd_addr` and `rd_len` stable, then → IDLE.
- DATA_RX:
  - Samples `w_data_bus` only in cycles with `m_valid`=1, LSB first.
  - On the WORD_SIZE-th bit, registers the assembled word to `mem_wdata` and `mem_addr` = base + word_index (modulo 2^SLAVE_ADDR_SIZE, wraps). It pulses `mem_we` and increments word_index.
  - `tx_done`=1 → IDLE after any word completing in the same cycle has been committed.
  - A partial word at `tx_done` is discarded.
- Aborts:
  - `split_on`=1 or `sel`=0 in any non-IDLE state → IDLE next cycle.
  - No `mem_we` or `rd_req` is issued for incomplete data.
  - A word completing in the abort cycle is dropped.
- `s_ready` = 0 in RD_ISSUE and whenever `rd_busy`=1; otherwise 1.

## Timing
- Reset values: `s_ready`=1 (registered as derived), `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `rd_req`=0, `rd_addr`=0, `rd_len`=0, state IDLE.
- All outputs are registered.
- `mem_we` asserts the cycle after the last data bit is sampled, for exactly one cycle.
- `rd_req` asserts the cycle after the RD_ISSUE entry cycle, once `rd_busy` is low.
- Address latency: SLAVE_ADDR_SIZE cycles from the first `sel` cycle to CMD entry.
- Back-to-back words: a new word's bit 0 may arrive the cycle after the previous word's last bit, with no gap.
- Reset mid-transaction clears all counters and partial words immediately.

## Structure
- Package `serial_bus_pkg` holds:
  - the state enum type;
  - the instruction codes (S_READ=1, S_WRITE=2, S_B_READ=3, S_B_WRITE=4), shared with the master side;
  - the default width constants.
- One sub-module `sipo_shift` (parameter WIDTH):
  - inputs: `clk`, `rst`, `clr`, `en`, `bit_in`;
  - outputs: `word`, `full`.
  - It is instantiated for address, burst length and data.

## Test plan
- Single write: `sel`, address 0x0A5 serial, then `m_valid` with data 0x3C → one `mem_we`, `mem_addr`=0x0A5, `mem_wdata`=0x3C; `tx_done` → IDLE.
- Burst write of 3 words 0x11, 0x22, 0x33 at 0xFFF → `mem_addr` 0xFFF, 0x000, 0x001 (wrap), three `mem_we` pulses.
- Burst read: address 0x010, burst length 5 → one `rd_req` with `rd_addr`=0x010, `rd_len`=5; burst length 0 → `rd_len`=1.
- Read with `rd_busy`=1 for 4 cycles → `s_ready`=0 and no `rd_req` until `rd_busy` falls, then exactly one pulse.
- `split_on` after 4 data bits → no `mem_we`, IDLE next cycle; `sel` drop mid-address → IDLE, no outputs.
- `rst` asserted in mid-DATA_RX → all outputs at reset values immediately; the next transaction completes normally.
